mat_mul_gen: RTL and testbench

Parametrised successor to the streaming matrix-multiply accelerator. Loads two square DIM×DIM operand matrices A and B over one AXI-Stream slave port, computes R = A·B with a single sequential MAC, and streams R out row-major over one AXI-Stream master port. Over the current accelerator it adds:
- selectable signedness;
- explicit accumulator width;
- frame-length checking;
- busy/done status;
- optional saturation.

It sits between the DMA MM2S and S2MM channels, in the same position as the current accelerator.

---
 rtl/mat_mul_gen_pkg.sv | 20 ++
 rtl/mat_mul_gen_mac.sv | 83 ++++++++
 rtl/mat_mul_gen.sv | 196 +++++++++++++++++++
 tb/tb_mat_mul_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mul_gen_pkg.sv
// Shared types and sizing helpers for the mat_mul_gen matrix-multiply accelerator.
package mat_mul_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Smallest accumulator that holds DIM full-width products without overflow.
   function automatic int acc_width_min(input int data_width, input int dim_log);
      return data_width + data_width + dim_log;
   endfunction

   // Address width of one DIM x DIM operand buffer.
   function automatic int idx_width(input int dim_log);
      return dim_log + dim_log;
   endfunction

endpackage

// File: rtl/mat_mul_gen_mac.sv
// Single MAC lane: signedness-aware product extension, wide accumulator, result narrowing.
// Define MAT_MUL_GEN_SAT_EN to clamp the result to the DATA_WIDTH range.
module mat_mul_gen_mac
   import mat_mul_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SIGNED     = 0,
   parameter int ACC_WIDTH  = acc_width_min(DATA_WIDTH, 6)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int PW = DATA_WIDTH + DATA_WIDTH;
   localparam int XW = ACC_WIDTH - PW;
   localparam bit IS_SIGNED = (SIGNED != 0);

   logic                 a_sign_s;
   logic                 b_sign_s;
   logic                 p_sign_s;
   logic [PW-1:0]        a_ext_s;
   logic [PW-1:0]        b_ext_s;
   logic [PW-1:0]        prod_s;
   logic [ACC_WIDTH-1:0] prod_ext_s;
   logic [ACC_WIDTH-1:0] acc_r;

   // Extend operands and product per signedness; the full product always fits in PW bits.
   always_comb begin
      a_sign_s   = IS_SIGNED & a[DATA_WIDTH-1];
      b_sign_s   = IS_SIGNED & b[DATA_WIDTH-1];
      a_ext_s    = {{DATA_WIDTH{a_sign_s}}, a};
      b_ext_s    = {{DATA_WIDTH{b_sign_s}}, b};
      prod_s     = a_ext_s * b_ext_s;
      p_sign_s   = IS_SIGNED & prod_s[PW-1];
      prod_ext_s = {{XW{p_sign_s}}, prod_s};
   end

   // Accumulator, cleared at the start of every element.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_WIDTH{1'b0}};
      end else if (clr) begin
         acc_r <= {ACC_WIDTH{1'b0}};
      end else if (en) begin
         acc_r <= acc_r + prod_ext_s;
      end
   end

`ifdef MAT_MUL_GEN_SAT_EN
   logic [ACC_WIDTH-DATA_WIDTH:0] hi_s;

   // Clamp: in range when every bit above the result field matches the kept sign.
   always_comb begin
      hi_s = acc_r[ACC_WIDTH-1:DATA_WIDTH-1];
      if (IS_SIGNED) begin
         if ((&hi_s) || !(|hi_s)) begin
            result = acc_r[DATA_WIDTH-1:0];
         end else if (acc_r[ACC_WIDTH-1]) begin
            result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         end
      end else begin
         if (|acc_r[ACC_WIDTH-1:DATA_WIDTH]) begin
            result = {DATA_WIDTH{1'b1}};
         end else begin
            result = acc_r[DATA_WIDTH-1:0];
         end
      end
   end
`else
   logic unused_acc_hi_s;

   assign result          = acc_r[DATA_WIDTH-1:0];
   assign unused_acc_hi_s = ^acc_r[ACC_WIDTH-1:DATA_WIDTH];
`endif

endmodule

// File: rtl/mat_mul_gen.sv
// Streaming R = A*B accelerator: loads A/B over s00_axis, streams R row-major on m00_axis.
// Define MAT_MUL_GEN_SAT_EN to saturate results instead of truncating them modulo 2**DATA_WIDTH.
module mat_mul_gen
   import mat_mul_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIM_LOG    = 6,
   parameter int SIGNED     = 0,
   parameter int ACC_WIDTH  = acc_width_min(DATA_WIDTH, DIM_LOG)
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                    s00_axis_tvalid,
   input  logic                    s00_axis_tlast,
   output logic                    s00_axis_tready,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tvalid,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   input  logic                    sel,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    len_err
);

   localparam int IDX_W = idx_width(DIM_LOG);
   localparam int DEPTH = 1 << IDX_W;
   localparam int CW    = DIM_LOG + 1;
   localparam logic [IDX_W-1:0] LAST_IDX    = {IDX_W{1'b1}};
   localparam logic [CW-1:0]    CNT_ACC_END = {1'b1, {DIM_LOG{1'b0}}};
   localparam logic [CW-1:0]    CNT_OUT     = CNT_ACC_END + CW'(1'b1);

   state_t                state_r;
   logic [IDX_W-1:0]      wr_cnt_r;
   logic [CW-1:0]         cnt_r;
   logic [DIM_LOG-1:0]    row_r, col_r;
   logic [DIM_LOG-1:0]    nxt_row_s, nxt_col_s, rd_row_s, rd_col_s, rd_k_s;
   logic [DATA_WIDTH-1:0] buf_a [DEPTH];
   logic [DATA_WIDTH-1:0] buf_b [DEPTH];
   logic [DATA_WIDTH-1:0] rd_a_r, rd_b_r, mac_res_s, m_data_r;
   logic                  s_ready_r, m_valid_r, m_last_r, busy_r, done_r, len_err_r;
   logic                  s_fire_s, m_fire_s, last_elem_s, mac_clr_s, mac_en_s;
   logic                  unused_strb_s;

   assign s00_axis_tready = s_ready_r;
   assign m00_axis_tdata  = m_data_r;
   assign m00_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};
   assign m00_axis_tvalid = m_valid_r;
   assign m00_axis_tlast  = m_last_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign len_err         = len_err_r;
   assign unused_strb_s   = ^s00_axis_tstrb;

   // Handshakes, index stepping and read addressing. In OUT the next element's k=0 operands
   // are fetched every cycle so the transfer edge doubles as that element's read cycle.
   always_comb begin
      s_fire_s    = s00_axis_tvalid & s_ready_r;
      m_fire_s    = m_valid_r & m00_axis_tready;
      last_elem_s = (&row_r) & (&col_r);
      nxt_col_s   = col_r + DIM_LOG'(1'b1);
      if (&col_r) begin
         nxt_row_s = row_r + DIM_LOG'(1'b1);
      end else begin
         nxt_row_s = row_r;
      end
      if (state_r == OUT) begin
         rd_row_s = nxt_row_s;
         rd_col_s = nxt_col_s;
         rd_k_s   = {DIM_LOG{1'b0}};
      end else begin
         rd_row_s = row_r;
         rd_col_s = col_r;
         rd_k_s   = cnt_r[DIM_LOG-1:0];
      end
      mac_clr_s = ((state_r == IDLE) & start) | ((state_r == OUT) & m_fire_s);
      mac_en_s  = (state_r == MAC) & (cnt_r != {CW{1'b0}}) & (cnt_r != CNT_OUT);
   end

   // Operand buffers: written while loading, read every cycle for the MAC lane.
   always_ff @(posedge s00_axi_aclk) begin
      if (s_fire_s && !sel) begin
         buf_a[wr_cnt_r] <= s00_axis_tdata;
      end
      if (s_fire_s && sel) begin
         buf_b[wr_cnt_r] <= s00_axis_tdata;
      end
      rd_a_r <= buf_a[{rd_row_s, rd_k_s}];
      rd_b_r <= buf_b[{rd_k_s, rd_col_s}];
   end

   // Load word counter and sticky frame-length error.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         wr_cnt_r  <= {IDX_W{1'b0}};
         len_err_r <= 1'b0;
      end else if (s_fire_s) begin
         if (s00_axis_tlast) begin
            if (wr_cnt_r != LAST_IDX) begin
               len_err_r <= 1'b1;
            end
            wr_cnt_r <= {IDX_W{1'b0}};
         end else if (wr_cnt_r == LAST_IDX) begin
            len_err_r <= 1'b1;
            wr_cnt_r  <= {IDX_W{1'b0}};
         end else begin
            wr_cnt_r <= wr_cnt_r + IDX_W'(1'b1);
         end
      end
   end

   // Compute FSM with registered AXIS and status outputs.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_r   <= IDLE;
         cnt_r     <= {CW{1'b0}};
         row_r     <= {DIM_LOG{1'b0}};
         col_r     <= {DIM_LOG{1'b0}};
         s_ready_r <= 1'b0;
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         m_data_r  <= {DATA_WIDTH{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r   <= MAC;
                  busy_r    <= 1'b1;
                  s_ready_r <= 1'b0;
                  cnt_r     <= {CW{1'b0}};
                  row_r     <= {DIM_LOG{1'b0}};
                  col_r     <= {DIM_LOG{1'b0}};
               end else begin
                  s_ready_r <= 1'b1;
               end
            end
            MAC: begin
               if (cnt_r == CNT_OUT) begin
                  state_r   <= OUT;
                  m_valid_r <= 1'b1;
                  m_data_r  <= mac_res_s;
                  m_last_r  <= last_elem_s;
               end else begin
                  cnt_r <= cnt_r + CW'(1'b1);
               end
            end
            OUT: begin
               if (m_fire_s) begin
                  m_valid_r <= 1'b0;
                  m_last_r  <= 1'b0;
                  if (last_elem_s) begin
                     state_r   <= IDLE;
                     busy_r    <= 1'b0;
                     done_r    <= 1'b1;
                     s_ready_r <= 1'b1;
                  end else begin
                     state_r <= MAC;
                     row_r   <= nxt_row_s;
                     col_r   <= nxt_col_s;
                     cnt_r   <= CW'(1'b1);
                  end
               end
            end
            default: begin
               state_r   <= IDLE;
               s_ready_r <= 1'b0;
               m_valid_r <= 1'b0;
               m_last_r  <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   mat_mul_gen_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIGNED     (SIGNED),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk    (s00_axi_aclk),
      .rst_n  (s00_axi_aresetn),
      .clr    (mac_clr_s),
      .en     (mac_en_s),
      .a      (rd_a_r),
      .b      (rd_b_r),
      .result (mac_res_s)
   );

endmodule

// File: tb/tb_mat_mul_gen.sv
// Directed bench for mat_mul_gen: 2x2 unsigned, 2x2 signed 8-bit, and 8x8 random instances.
module tb_mat_mul_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   int checks = 0;
   int errors = 0;

`ifdef MAT_MUL_GEN_SAT_EN
   localparam logic [7:0] EXP1 = 8'd127;
`else
   localparam logic [7:0] EXP1 = 8'd32;
`endif

   logic [31:0] s_data0, m_data0, s_data2, m_data2;
   logic [7:0]  s_data1, m_data1;
   logic [3:0]  m_strb0, m_strb2;
   logic        m_strb1;
   logic s_valid0, s_last0, s_ready0, sel0, start0, m_valid0, m_last0, m_ready0, busy0, done0, lerr0;
   logic s_valid1, s_last1, s_ready1, sel1, start1, m_valid1, m_last1, m_ready1, busy1, done1, lerr1;
   logic s_valid2, s_last2, s_ready2, sel2, start2, m_valid2, m_last2, m_ready2, busy2, done2, lerr2;
   logic [31:0] a2 [64];
   logic [31:0] b2 [64];
   logic [31:0] r2 [64];

   mat_mul_gen #(.DATA_WIDTH(32), .DIM_LOG(1), .SIGNED(0)) u0 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .s00_axis_tdata(s_data0), .s00_axis_tstrb(4'hF),
      .s00_axis_tvalid(s_valid0), .s00_axis_tlast(s_last0), .s00_axis_tready(s_ready0),
      .m00_axis_tdata(m_data0), .m00_axis_tstrb(m_strb0), .m00_axis_tvalid(m_valid0),
      .m00_axis_tlast(m_last0), .m00_axis_tready(m_ready0), .sel(sel0), .start(start0),
      .busy(busy0), .done(done0), .len_err(lerr0));

   mat_mul_gen #(.DATA_WIDTH(8), .DIM_LOG(1), .SIGNED(1)) u1 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .s00_axis_tdata(s_data1), .s00_axis_tstrb(1'b1),
      .s00_axis_tvalid(s_valid1), .s00_axis_tlast(s_last1), .s00_axis_tready(s_ready1),
      .m00_axis_tdata(m_data1), .m00_axis_tstrb(m_strb1), .m00_axis_tvalid(m_valid1),
      .m00_axis_tlast(m_last1), .m00_axis_tready(m_ready1), .sel(sel1), .start(start1),
      .busy(busy1), .done(done1), .len_err(lerr1));

   mat_mul_gen #(.DATA_WIDTH(32), .DIM_LOG(3), .SIGNED(0)) u2 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .s00_axis_tdata(s_data2), .s00_axis_tstrb(4'hF),
      .s00_axis_tvalid(s_valid2), .s00_axis_tlast(s_last2), .s00_axis_tready(s_ready2),
      .m00_axis_tdata(m_data2), .m00_axis_tstrb(m_strb2), .m00_axis_tvalid(m_valid2),
      .m00_axis_tlast(m_last2), .m00_axis_tready(m_ready2), .sel(sel2), .start(start2),
      .busy(busy2), .done(done2), .len_err(lerr2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One word into instance u; the block is in IDLE, so tready is already high.
   task automatic push(input int u, input logic [31:0] d, input logic s, input logic l);
      case (u)
         0: begin s_data0 = d; sel0 = s; s_last0 = l; s_valid0 = 1'b1; end
         1: begin s_data1 = d[7:0]; sel1 = s; s_last1 = l; s_valid1 = 1'b1; end
         default: begin s_data2 = d; sel2 = s; s_last2 = l; s_valid2 = 1'b1; end
      endcase
      @(posedge clk); #1;
      s_valid0 = 1'b0; s_last0 = 1'b0;
      s_valid1 = 1'b0; s_last1 = 1'b0;
      s_valid2 = 1'b0; s_last2 = 1'b0;
   endtask

   // Start u0 and collect its 2x2 result with a repeating tready pattern.
   task automatic run0(input logic [3:0] pat, input logic poke);
      logic [31:0] exp [4];
      int n = 0, cyc = 0, first = -1, extra = 0;
      logic held = 1'b0;
      logic [31:0] hv = 32'd0;
      exp = '{32'd19, 32'd22, 32'd43, 32'd50};
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      check("busy_rise", busy0, 1'b1);
      while (n < 4 && cyc < 100) begin
         if (m_valid0 && first < 0) first = cyc;
         if (held) begin
            check("hold_valid", m_valid0, 1'b1);
            check("hold_data", m_data0, hv);
         end
         extra += done0;
         start0 = poke && (cyc == 2);
         m_ready0 = pat[cyc % 4];
         if (m_valid0 && m_ready0) begin
            check("res_data", m_data0, exp[n]);
            check("res_last", m_last0, n == 3);
            n++;
            held = 1'b0;
         end else begin
            held = m_valid0;
            hv = m_data0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start0 = 1'b0;
      check("res_count", n, 4);
      check("first_latency", first, 4);
      check("done_pulse", done0, 1'b1);
      check("busy_fall", busy0, 1'b0);
      check("valid_after", m_valid0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         extra += done0 + m_valid0;
      end
      check("no_extra_done_or_result", extra, 0);
      m_ready0 = 1'b0;
   endtask

   initial begin
      int got;
      logic [31:0] acc;
      rst_n = 1'b0;
      {s_data0, s_valid0, s_last0, sel0, start0, m_ready0} = '0;
      {s_data1, s_valid1, s_last1, sel1, start1, m_ready1} = '0;
      {s_data2, s_valid2, s_last2, sel2, start2, m_ready2} = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tready", s_ready0, 1'b0);
      check("rst_tvalid", m_valid0, 1'b0);
      check("rst_tlast", m_last0, 1'b0);
      check("rst_tdata", m_data0, 32'd0);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_len_err", lerr0, 1'b0);
      check("tstrb", {m_strb0, m_strb1, m_strb2}, 9'h1FF);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_tready", s_ready0, 1'b1);

      // 2x2 unsigned: A=[1,2;3,4], B=[5,6;7,8]
      for (int i = 0; i < 4; i++) push(0, i + 1, 1'b0, i == 3);
      for (int i = 0; i < 4; i++) push(0, i + 5, 1'b1, i == 3);
      check("clean_len_err", lerr0, 1'b0);
      run0(4'b1111, 1'b0);
      check("tready_back", s_ready0, 1'b1);
      run0(4'b1001, 1'b0);
      run0(4'b1111, 1'b1);
      check("len_err_still0", lerr0, 1'b0);

      // short frame: tlast on the 3rd word
      for (int i = 0; i < 3; i++) push(0, i + 1, 1'b0, i == 2);
      check("short_len_err", lerr0, 1'b1);
      for (int i = 0; i < 4; i++) push(0, i + 1, 1'b0, i == 3);
      run0(4'b1111, 1'b0);
      check("len_err_sticky", lerr0, 1'b1);

      // 8-bit signed, all 100: true 20000 -> 32 truncated or 127 saturated; B has no tlast
      for (int i = 0; i < 4; i++) push(1, 32'd100, 1'b0, i == 3);
      check("u1_len_err0", lerr1, 1'b0);
      for (int i = 0; i < 4; i++) push(1, 32'd100, 1'b1, 1'b0);
      check("u1_no_tlast_len_err", lerr1, 1'b1);
      m_ready1 = 1'b1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
         if (m_valid1) begin
            check("narrow_data", m_data1, EXP1);
            got++;
         end
         @(posedge clk); #1;
      end
      check("u1_count", got, 4);

      // 8x8 random, modulo 2**32 reference
      for (int i = 0; i < 64; i++) begin a2[i] = $urandom; b2[i] = $urandom; end
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            acc = 32'd0;
            for (int k = 0; k < 8; k++) acc += a2[r*8+k] * b2[k*8+c];
            r2[r*8+c] = acc;
         end
      end
      for (int i = 0; i < 64; i++) push(2, a2[i], 1'b0, i == 63);
      for (int i = 0; i < 64; i++) push(2, b2[i], 1'b1, i == 63);
      m_ready2 = 1'b1;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 1000 && got < 64; cyc++) begin
         if (m_valid2) begin
            check("rand_data", m_data2, r2[got]);
            check("rand_last", m_last2, got == 63);
            got++;
         end
         @(posedge clk); #1;
      end
      check("rand_count", got, 64);
      check("rand_done", done2, 1'b1);

      // reset while presenting the 6th result of a recompute
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (m_valid2) begin
            if (got == 5) break;
            got++;
         end
         @(posedge clk); #1;
      end
      check("pre_reset_valid", m_valid2, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_tvalid", m_valid2, 1'b0);
      check("mid_reset_busy", busy2, 1'b0);
      check("mid_reset_tlast", m_last2, 1'b0);
      check("mid_reset_len_err", lerr0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_tready", s_ready2, 1'b1);
      check("post_reset_tvalid", m_valid2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
